io_serial_port: RTL and testbench

- Serial I/O port for the 16-bit basic computer.
- Receive side deserialises an 8N1 UART line into INPR and raises FGI, which the controller polls for input or uses for its interrupt cycle.
- Transmit side accepts OUTR from the controller and serialises it, raising FGO when the port is ready for the next byte.
- Sits directly upstream of the controller, supplying FGI and INPR.

---
 rtl/basic_computer_pkg.sv | 17 +
 rtl/io_uart_tx.sv | 107 ++++++++++
 rtl/io_serial_port.sv | 201 ++++++++++++++++++++
 tb/tb_io_serial_port.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/basic_computer_pkg.sv
// Shared definitions for the basic computer serial I/O slice.
// Both the receiver and the transmitter use the same four-phase frame walk,
// so they share one state encoding.

package basic_computer_pkg;

   typedef enum logic [1:0] {
      SER_IDLE  = 2'd0,
      SER_START = 2'd1,
      SER_DATA  = 2'd2,
      SER_STOP  = 2'd3
   } ser_state_e;

   // 50 MHz system clock at 115200 baud.
   localparam int DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/io_uart_tx.sv
// Transmit half of the serial port: holds OUTR, serialises it as an 8N1 frame
// and reports readiness through fgo. A load request while busy is ignored.

module io_uart_tx
   import basic_computer_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [7:0] outr_in,
   input  logic       out_ld,
   output logic       tx,
   output logic       fgo
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_RELOAD = CW'(CLKS_PER_BIT - 1);

   ser_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    outr_q, outr_d;
   logic          cnt_zero;

   assign cnt_zero = (cnt_q == '0);

   // State register: frame phase, bit timer, bit index and the OUTR holding register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= SER_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         outr_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         outr_q  <= outr_d;
      end
   end

   // Next-state logic: each phase lasts one full bit time, counted down to zero.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      outr_d  = outr_q;
      case (state_q)
         SER_IDLE: begin
            if (out_ld) begin
               outr_d  = outr_in;
               cnt_d   = BIT_RELOAD;
               bit_d   = '0;
               state_d = SER_START;
            end
         end
         SER_START: begin
            if (cnt_zero) begin
               cnt_d   = BIT_RELOAD;
               state_d = SER_DATA;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         SER_DATA: begin
            if (cnt_zero) begin
               cnt_d = BIT_RELOAD;
               if (bit_q == 3'd7) begin
                  state_d = SER_STOP;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         SER_STOP: begin
            if (cnt_zero) begin
               state_d = SER_IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: begin
            state_d = SER_IDLE;
         end
      endcase
   end

   // Output logic: line level per phase, ready flag whenever no frame is in flight.
   always_comb begin
      tx  = 1'b1;
      fgo = 1'b0;
      case (state_q)
         SER_IDLE: begin
            tx  = 1'b1;
            fgo = 1'b1;
         end
         SER_START: tx = 1'b0;
         SER_DATA:  tx = outr_q[bit_q];
         SER_STOP:  tx = 1'b1;
         default:   tx = 1'b1;
      endcase
   end

endmodule

// File: rtl/io_serial_port.sv
// Serial I/O port for the 16-bit basic computer. The receive path synchronises
// the rx pin, samples each 8N1 frame at mid-bit and presents the byte as INPR
// with the FGI flag; the transmit path lives in io_uart_tx.

module io_serial_port
   import basic_computer_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int SYNC_STAGES  = 2
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       rx,
   output logic       tx,
   output logic [7:0] inpr,
   output logic       fgi,
   input  logic       fgi_clr,
   input  logic [7:0] outr_in,
   input  logic       out_ld,
   output logic       fgo,
   output logic       overrun,
   output logic       frame_err
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_RELOAD  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_RELOAD = CW'(CLKS_PER_BIT / 2 - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   rxs;

   ser_state_e    rx_state_q, rx_state_d;
   logic [CW-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]    rx_bit_q, rx_bit_d;
   logic          rx_cnt_zero;

   logic [7:0] shift_q, shift_d;
   logic [7:0] inpr_q, inpr_d;
   logic       fgi_q, fgi_d;
   logic       overrun_q, overrun_d;
   logic       frame_err_q, frame_err_d;

   logic rx_sample;
   logic rx_stop_ok;
   logic rx_stop_bad;

   assign rxs         = sync_q[SYNC_STAGES-1];
   assign rx_cnt_zero = (rx_cnt_q == '0);

   // Metastability chain: the pin enters at bit 0 and the FSM only ever sees the last stage.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], rx};
   end

   // Synchroniser flops reset to the idle-high line level so no false start follows reset.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '1;
      end else begin
         sync_q <= sync_d;
      end
   end

   // RX state register together with the receive datapath and the sticky flags.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rx_state_q  <= SER_IDLE;
         rx_cnt_q    <= '0;
         rx_bit_q    <= '0;
         shift_q     <= '0;
         inpr_q      <= '0;
         fgi_q       <= 1'b0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         rx_state_q  <= rx_state_d;
         rx_cnt_q    <= rx_cnt_d;
         rx_bit_q    <= rx_bit_d;
         shift_q     <= shift_d;
         inpr_q      <= inpr_d;
         fgi_q       <= fgi_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
      end
   end

   // RX next-state: half a bit to reach mid start bit, then whole bits to each later midpoint.
   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      case (rx_state_q)
         SER_IDLE: begin
            if (!rxs) begin
               rx_cnt_d   = HALF_RELOAD;
               rx_bit_d   = '0;
               rx_state_d = SER_START;
            end
         end
         SER_START: begin
            if (rx_cnt_zero) begin
               if (rxs) begin
                  rx_state_d = SER_IDLE;
               end else begin
                  rx_cnt_d   = BIT_RELOAD;
                  rx_state_d = SER_DATA;
               end
            end else begin
               rx_cnt_d = rx_cnt_q - CW'(1);
            end
         end
         SER_DATA: begin
            if (rx_cnt_zero) begin
               rx_cnt_d = BIT_RELOAD;
               if (rx_bit_q == 3'd7) begin
                  rx_state_d = SER_STOP;
               end else begin
                  rx_bit_d = rx_bit_q + 3'd1;
               end
            end else begin
               rx_cnt_d = rx_cnt_q - CW'(1);
            end
         end
         SER_STOP: begin
            if (rx_cnt_zero) begin
               rx_state_d = SER_IDLE;
            end else begin
               rx_cnt_d = rx_cnt_q - CW'(1);
            end
         end
         default: begin
            rx_state_d = SER_IDLE;
         end
      endcase
   end

   // RX outputs: mid-bit strobes for data sampling and for judging the stop bit.
   always_comb begin
      rx_sample   = 1'b0;
      rx_stop_ok  = 1'b0;
      rx_stop_bad = 1'b0;
      if (rx_cnt_zero) begin
         case (rx_state_q)
            SER_DATA: rx_sample = 1'b1;
            SER_STOP: begin
               rx_stop_ok  = rxs;
               rx_stop_bad = !rxs;
            end
            default: begin
               rx_sample = 1'b0;
            end
         endcase
      end
   end

   // Receive datapath: LSB-first shift, INPR hand-off and flag bookkeeping.
   // A completing byte in the same cycle as fgi_clr counts as consumed-then-refilled.
   always_comb begin
      shift_d     = shift_q;
      inpr_d      = inpr_q;
      fgi_d       = fgi_q;
      overrun_d   = overrun_q;
      frame_err_d = frame_err_q;
      if (rx_sample) begin
         shift_d = {rxs, shift_q[7:1]};
      end
      if (fgi_clr) begin
         fgi_d       = 1'b0;
         overrun_d   = 1'b0;
         frame_err_d = 1'b0;
      end
      if (rx_stop_ok) begin
         if (!fgi_q || fgi_clr) begin
            inpr_d = shift_q;
            fgi_d  = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
      if (rx_stop_bad) begin
         frame_err_d = 1'b1;
      end
   end

   assign inpr      = inpr_q;
   assign fgi       = fgi_q;
   assign overrun   = overrun_q;
   assign frame_err = frame_err_q;

   io_uart_tx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_tx (
      .clock   (clock),
      .reset_n (reset_n),
      .outr_in (outr_in),
      .out_ld  (out_ld),
      .tx      (tx),
      .fgo     (fgo)
   );

endmodule

// File: tb/tb_io_serial_port.sv
// Directed bench for io_serial_port with CLKS_PER_BIT=8 and SYNC_STAGES=2.
// Inputs change on the falling clock edge and outputs are read there too.

module tb_io_serial_port;

   localparam int CLKS = 8;

   logic       clock   = 1'b0;
   logic       reset_n = 1'b1;
   logic       rx      = 1'b1;
   logic       fgi_clr = 1'b0;
   logic       out_ld  = 1'b0;
   logic [7:0] outr_in = 8'h00;
   logic       tx;
   logic [7:0] inpr;
   logic       fgi;
   logic       fgo;
   logic       overrun;
   logic       frame_err;

   int   testsRun    = 0;
   int   testsFailed = 0;
   int   cycle       = 0;
   int   fallCycle   = 0;
   int   riseCycle   = 0;
   logic fgiPrev     = 1'b0;
   logic [9:0] txFrame;

   io_serial_port #(
      .CLKS_PER_BIT(CLKS),
      .SYNC_STAGES (2)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .rx        (rx),
      .tx        (tx),
      .inpr      (inpr),
      .fgi       (fgi),
      .fgi_clr   (fgi_clr),
      .outr_in   (outr_in),
      .out_ld    (out_ld),
      .fgo       (fgo),
      .overrun   (overrun),
      .frame_err (frame_err)
   );

   // Free-running 100 MHz-style clock for the bench.
   always #5 clock = ~clock;

   // Counts rising edges so receive latency can be measured in clocks.
   always @(posedge clock) begin
      cycle <= cycle + 1;
   end

   // Notes the edge count at which fgi was first seen high.
   always @(negedge clock) begin
      if (fgi && !fgiPrev) begin
         riseCycle <= cycle;
      end
      fgiPrev <= fgi;
   end

   // Hard stop in case the sequence ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Counts one comparison and reports it when observed and expected differ.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      testsRun++;
      if (got !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Drives one 8N1 frame on rx, each bit held for CLKS clocks; the stop level is selectable.
   task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
      @(negedge clock);
      rx = 1'b0;
      fallCycle = cycle;
      repeat (CLKS) @(negedge clock);
      for (int i = 0; i < 8; i++) begin
         rx = data[i];
         repeat (CLKS) @(negedge clock);
      end
      rx = stopBit;
      repeat (CLKS) @(negedge clock);
      rx = 1'b1;
   endtask

   // One-clock INP acknowledge from the controller.
   task automatic pulseFgiClr();
      @(negedge clock);
      fgi_clr = 1'b1;
      @(negedge clock);
      fgi_clr = 1'b0;
   endtask

   initial begin
      #1 reset_n = 1'b0;
      repeat (3) @(negedge clock);
      checkOutput("reset tx", 32'(tx), 32'd1);
      checkOutput("reset fgo", 32'(fgo), 32'd1);
      checkOutput("reset fgi", 32'(fgi), 32'd0);
      checkOutput("reset inpr", 32'(inpr), 32'h00);
      checkOutput("reset overrun", 32'(overrun), 32'd0);
      checkOutput("reset frame_err", 32'(frame_err), 32'd0);
      reset_n = 1'b1;
      repeat (4) @(negedge clock);

      $display("[TB] receive 0xA5");
      applyStimulus(8'hA5, 1'b1);
      checkOutput("A5 fgi", 32'(fgi), 32'd1);
      checkOutput("A5 inpr", 32'(inpr), 32'hA5);
      checkOutput("A5 latency", 32'(riseCycle - fallCycle), 32'd79);
      pulseFgiClr();
      checkOutput("A5 fgi cleared", 32'(fgi), 32'd0);

      $display("[TB] overrun 0x3C then 0x81");
      applyStimulus(8'h3C, 1'b1);
      checkOutput("3C fgi", 32'(fgi), 32'd1);
      checkOutput("3C inpr", 32'(inpr), 32'h3C);
      applyStimulus(8'h81, 1'b1);
      checkOutput("81 inpr kept", 32'(inpr), 32'h3C);
      checkOutput("81 overrun", 32'(overrun), 32'd1);
      checkOutput("81 fgi still set", 32'(fgi), 32'd1);
      pulseFgiClr();
      checkOutput("overrun clr fgi", 32'(fgi), 32'd0);
      checkOutput("overrun cleared", 32'(overrun), 32'd0);

      $display("[TB] framing error on 0x55");
      applyStimulus(8'h55, 1'b0);
      repeat (12) @(negedge clock);
      checkOutput("55 fgi", 32'(fgi), 32'd0);
      checkOutput("55 frame_err", 32'(frame_err), 32'd1);
      checkOutput("55 inpr kept", 32'(inpr), 32'h3C);
      pulseFgiClr();
      checkOutput("frame_err cleared", 32'(frame_err), 32'd0);

      $display("[TB] start-bit glitch");
      @(negedge clock);
      rx = 1'b0;
      repeat (3) @(negedge clock);
      rx = 1'b1;
      repeat (20) @(negedge clock);
      checkOutput("glitch fgi", 32'(fgi), 32'd0);
      checkOutput("glitch overrun", 32'(overrun), 32'd0);
      checkOutput("glitch frame_err", 32'(frame_err), 32'd0);
      applyStimulus(8'h5A, 1'b1);
      checkOutput("post-glitch inpr", 32'(inpr), 32'h5A);
      checkOutput("post-glitch latency", 32'(riseCycle - fallCycle), 32'd79);
      pulseFgiClr();

      $display("[TB] transmit 0xC3");
      txFrame = {1'b1, 8'hC3, 1'b0};
      @(negedge clock);
      outr_in = 8'hC3;
      out_ld  = 1'b1;
      @(negedge clock);
      out_ld  = 1'b0;
      checkOutput("tx fgo busy", 32'(fgo), 32'd0);
      checkOutput("tx start level", 32'(tx), 32'd0);
      for (int j = 1; j <= 80; j++) begin
         @(negedge clock);
         if (j == 20) begin
            outr_in = 8'hFF;
            out_ld  = 1'b1;
         end
         if (j == 21) begin
            out_ld = 1'b0;
         end
         if ((j % CLKS) == 4) begin
            checkOutput($sformatf("tx bit %0d", j / CLKS), 32'(tx), 32'(txFrame[j / CLKS]));
         end
         if (j == 79) begin
            checkOutput("tx fgo before end", 32'(fgo), 32'd0);
         end
         if (j == 80) begin
            checkOutput("tx fgo done", 32'(fgo), 32'd1);
            checkOutput("tx idle level", 32'(tx), 32'd1);
         end
      end

      $display("[TB] reset mid-frame");
      applyStimulus(8'h77, 1'b1);
      checkOutput("77 fgi", 32'(fgi), 32'd1);
      @(negedge clock);
      rx      = 1'b0;
      outr_in = 8'h00;
      out_ld  = 1'b1;
      @(negedge clock);
      out_ld  = 1'b0;
      repeat (30) @(negedge clock);
      checkOutput("pre-reset tx low", 32'(tx), 32'd0);
      #2 reset_n = 1'b0;
      #1;
      checkOutput("abort tx", 32'(tx), 32'd1);
      checkOutput("abort fgo", 32'(fgo), 32'd1);
      checkOutput("abort fgi", 32'(fgi), 32'd0);
      checkOutput("abort inpr", 32'(inpr), 32'h00);
      rx = 1'b1;
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      repeat (10) @(negedge clock);
      checkOutput("after release fgi", 32'(fgi), 32'd0);
      checkOutput("after release tx", 32'(tx), 32'd1);
      applyStimulus(8'h0F, 1'b1);
      checkOutput("0F fgi", 32'(fgi), 32'd1);
      checkOutput("0F inpr", 32'(inpr), 32'h0F);
      checkOutput("0F latency", 32'(riseCycle - fallCycle), 32'd79);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
